sg_window_feeder: RTL and testbench

Streaming sliding-window builder upstream of the Savitzky-Golay smoother. It accepts one sample per valid/ready handshake and presents one full WINDOW_SIZE-sample window per output sample, centred on sample index i. Samples outside [0, DATA_SIZE-1] are edge-padded. The smoother fits its polynomial per window without re-reading the whole data array.

---
 rtl/sg_window_feeder_if.sv | 42 ++++
 rtl/sg_window_feeder.sv | 192 +++++++++++++++++++
 tb/tb_sg_window_feeder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sg_window_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sg_window_feeder_if
//  Description : Bundles the control, sample-input and window-output signals
//                of the Savitzky-Golay window feeder.
//                  start      - single-cycle run request
//                  in_valid   - in_data holds a sample
//                  in_data    - signed input sample
//                  in_ready   - feeder accepts the sample this cycle
//                  win_valid  - win_data/win_center hold a complete window
//                  win_data   - WINDOW_SIZE packed samples, slot 0 oldest
//                  win_center - index of the window's centre sample
//                  win_ready  - consumer takes the window this cycle
//                  done       - one-cycle pulse after the last window
//                master = producer/consumer side, slave = feeder side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sg_window_feeder_if #(
    parameter int WINDOW_SIZE = 7,
    parameter int DATA_WIDTH  = 32
);
    logic                                start;
    logic                                in_valid;
    logic signed [DATA_WIDTH-1:0]        in_data;
    logic                                in_ready;
    logic                                win_valid;
    logic [WINDOW_SIZE*DATA_WIDTH-1:0]   win_data;
    logic [15:0]                         win_center;
    logic                                win_ready;
    logic                                done;

    modport master (
        output start, in_valid, in_data, win_ready,
        input  in_ready, win_valid, win_data, win_center, done
    );

    modport slave (
        input  start, in_valid, in_data, win_ready,
        output in_ready, win_valid, win_data, win_center, done
    );
endinterface
`default_nettype wire

// File: rtl/sg_window_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : sg_window_feeder
//  Description : Streaming sliding-window builder for a Savitzky-Golay
//                smoother. Accepts DATA_SIZE samples per run and emits
//                DATA_SIZE windows of WINDOW_SIZE samples, window i centred
//                on sample i, with edge padding outside [0, DATA_SIZE-1].
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - sg_window_feeder_if.slave (start, in_* sample
//                         stream, win_* window stream, done pulse)
//  Config      : SG_WIN_ZERO_PAD_EN defined   -> pad value is 0 at both ends
//                SG_WIN_ZERO_PAD_EN undefined -> edge replicate (x0 on the
//                left, x(DATA_SIZE-1) on the right)
//  Revision    : 1.0 - initial release
// ============================================================================
module sg_window_feeder #(
    parameter int WINDOW_SIZE = 7,
    parameter int DATA_WIDTH  = 32,
    parameter int DATA_SIZE   = 1000
) (
    input  wire               clk,
    input  wire               rst_n,
    sg_window_feeder_if.slave bus
);

    localparam logic [1:0]  c_IDLE   = 2'd0;
    localparam logic [1:0]  c_FILL   = 2'd1;
    localparam logic [1:0]  c_STREAM = 2'd2;
    localparam logic [1:0]  c_FLUSH  = 2'd3;

    localparam logic [15:0] c_HALF   = 16'(WINDOW_SIZE / 2);
    localparam logic [15:0] c_LAST   = 16'(DATA_SIZE - 1);

    logic [1:0]                     r_state;
    logic [15:0]                    r_cnt;        // samples accepted this run
    logic [15:0]                    r_center;
    logic                           r_win_valid;
    logic                           r_done;
    logic signed [DATA_WIDTH-1:0]   r_win [WINDOW_SIZE];

    logic                           w_in_ready;
    logic                           w_accept;
    logic                           w_xfer;
    logic                           w_last_win;
    logic                           w_load_first;
    logic                           w_shift;
    logic signed [DATA_WIDTH-1:0]   w_new;
    logic signed [DATA_WIDTH-1:0]   w_pad_left;
    logic signed [DATA_WIDTH-1:0]   w_pad_right;
    logic [WINDOW_SIZE*DATA_WIDTH-1:0] w_win_data;

    // ------------------------------------------------------------------
    // Pad selection. In replicate mode the left pad is the first sample
    // itself (it is on the bus when it is loaded) and the right pad is the
    // newest slot, which after the final sample holds x(DATA_SIZE-1) and
    // keeps holding it as the same value is shifted in again.
    // ------------------------------------------------------------------
`ifdef SG_WIN_ZERO_PAD_EN
    assign w_pad_left  = '0;
    assign w_pad_right = '0;
`else
    assign w_pad_left  = bus.in_data;
    assign w_pad_right = r_win[WINDOW_SIZE-1];
`endif

    // ------------------------------------------------------------------
    // Handshakes. In STREAM a new sample may only enter when the current
    // window is absent or leaving this cycle, so in_ready looks at
    // win_ready combinationally to keep one-per-cycle throughput.
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            c_FILL:   w_in_ready = 1'b1;
            c_STREAM: w_in_ready = !r_win_valid || bus.win_ready;
            default:  w_in_ready = 1'b0;
        endcase
    end

    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_xfer     = r_win_valid && bus.win_ready;
    assign w_last_win = (r_center == c_LAST);

    // First sample of a run fills the whole window with pad plus x0; every
    // later sample, and every flushed window after the first, is a shift.
    assign w_load_first = (r_state == c_FILL) && w_accept && (r_cnt == 16'd0);
    assign w_shift      = (w_accept && !w_load_first) ||
                          ((r_state == c_FLUSH) && w_xfer && !w_last_win);
    assign w_new        = (r_state == c_FLUSH) ? w_pad_right : bus.in_data;

    // ------------------------------------------------------------------
    // Control FSM and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_center    <= '0;
            r_win_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_cnt    <= '0;
                        r_center <= '0;
                        r_state  <= c_FILL;
                    end
                end

                c_FILL: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 16'd1;
                        // Sample H completes the first window (centre 0).
                        if (r_cnt == c_HALF) begin
                            r_win_valid <= 1'b1;
                            r_center    <= '0;
                            r_state     <= c_STREAM;
                        end
                    end
                end

                c_STREAM: begin
                    if (w_accept) begin
                        r_cnt       <= r_cnt + 16'd1;
                        r_win_valid <= 1'b1;
                        // Newest sample index minus H is the centre, which
                        // stays right whether or not the previous window
                        // left earlier without a replacement.
                        r_center    <= r_cnt - c_HALF;
                        if (r_cnt == c_LAST) begin
                            r_state <= c_FLUSH;
                        end
                    end else if (w_xfer) begin
                        r_win_valid <= 1'b0;
                    end
                end

                c_FLUSH: begin
                    if (w_xfer) begin
                        if (w_last_win) begin
                            r_win_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= c_IDLE;
                        end else begin
                            r_center <= r_center + 16'd1;
                        end
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Window shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < WINDOW_SIZE; k++) begin
                r_win[k] <= '0;
            end
        end else if (w_load_first) begin
            for (int k = 0; k < WINDOW_SIZE - 1; k++) begin
                r_win[k] <= w_pad_left;
            end
            r_win[WINDOW_SIZE-1] <= bus.in_data;
        end else if (w_shift) begin
            for (int k = 0; k < WINDOW_SIZE - 1; k++) begin
                r_win[k] <= r_win[k+1];
            end
            r_win[WINDOW_SIZE-1] <= w_new;
        end
    end

    for (genvar k = 0; k < WINDOW_SIZE; k++) begin : g_pack
        assign w_win_data[k*DATA_WIDTH +: DATA_WIDTH] = r_win[k];
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.win_valid  = r_win_valid;
    assign bus.win_data   = w_win_data;
    assign bus.win_center = r_center;
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sg_window_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sg_window_feeder
//  Description : Self-checking bench for sg_window_feeder: table of expected
//                windows for ramps, randomized data/handshakes against a
//                reference model, protocol and mid-run reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sg_window_feeder;

    localparam int WS = 7;
    localparam int DW = 32;
    localparam int DS = 16;
    localparam int H  = WS / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    sg_window_feeder_if #(.WINDOW_SIZE(WS), .DATA_WIDTH(DW)) bus ();

    sg_window_feeder #(
        .WINDOW_SIZE (WS),
        .DATA_WIDTH  (DW),
        .DATA_SIZE   (DS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic signed [DW-1:0] xs  [DS];
    logic [WS*DW-1:0]     cap [DS];
    int                   n_acc;
    int                   n_win;

    typedef struct {
        int base;
        int center;
        int exp [WS];
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference window: slot k holds sample c-H+k, clamped to the data range
    // (edge replicate) or zero outside it.
    function automatic logic [WS*DW-1:0] model_win(input int c);
        logic [WS*DW-1:0]     r;
        logic signed [DW-1:0] v;
        int                   idx;
        r = '0;
        for (int k = 0; k < WS; k++) begin
            idx = c - H + k;
            if (idx < 0) begin
`ifdef SG_WIN_ZERO_PAD_EN
                v = '0;
`else
                v = xs[0];
`endif
            end else if (idx > DS - 1) begin
`ifdef SG_WIN_ZERO_PAD_EN
                v = '0;
`else
                v = xs[DS-1];
`endif
            end else begin
                v = xs[idx];
            end
            r[k*DW +: DW] = v;
        end
        return r;
    endfunction

    task automatic fill_ramp(input int base);
        for (int i = 0; i < DS; i++) xs[i] = DW'(base + i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < DS; i++) xs[i] = $urandom;
    endtask

    // vmode: 0 in_valid always high, 1 random.
    // rmode: 0 win_ready always high, 1 toggling, 2 random.
    // start_at: loop cycle at which start is pulsed again (-1 none).
    // abort_at: window count after which rst_n is pulled low (-1 none).
    task automatic run(input int vmode, input int rmode, input int start_at, input int abort_at);
        int                cyc;
        int                sent;
        bit                fin;
        bit                exp_done;
        bit                next_done;
        bit                prev_stall;
        bit                aborted;
        logic [WS*DW-1:0]  prev_data;
        logic [15:0]       prev_c;

        cyc = 0; sent = 0; fin = 0; exp_done = 0; prev_stall = 0; aborted = 0;
        prev_data = '0; prev_c = '0;
        n_acc = 0; n_win = 0;

        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.win_ready = 1'b0;
        bus.start     = 1'b1;
        @(negedge clk);

        while (!fin && cyc < 400) begin
            bus.start     = (cyc == start_at);
            bus.in_valid  = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.in_data   = (sent < DS) ? xs[sent] : DW'(32'h5A5A_0F0F);
            bus.win_ready = (rmode == 0) ? 1'b1 :
                            (rmode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            #1;
            chk("done", 256'(bus.done), 256'(exp_done));
            if (exp_done) begin
                chk("in_ready_in_done", 256'(bus.in_ready), 256'(0));
                fin = 1;
            end else begin
                next_done = 0;
                if (prev_stall)
                    chk("stall_hold", {bus.win_center, bus.win_data}, {prev_c, prev_data});
                if (bus.win_valid && !bus.win_ready)
                    chk("in_ready_bp", 256'(bus.in_ready), 256'(0));
                if (bus.in_valid && bus.in_ready) begin
                    n_acc++;
                    sent++;
                end
                if (bus.win_valid && bus.win_ready) begin
                    chk("center", 256'(bus.win_center), 256'(n_win));
                    chk("window", 256'(bus.win_data), 256'(model_win(n_win)));
                    if (n_win < DS) cap[n_win] = bus.win_data;
                    n_win++;
                    next_done = (n_win == DS);
                end
                prev_stall = bus.win_valid && !bus.win_ready;
                prev_data  = bus.win_data;
                prev_c     = bus.win_center;
                exp_done   = next_done;
                if (abort_at >= 0 && n_win == abort_at) begin
                    #1 rst_n = 1'b0;
                    #1;
                    chk("rst_in_ready",   256'(bus.in_ready),   256'(0));
                    chk("rst_win_valid",  256'(bus.win_valid),  256'(0));
                    chk("rst_win_data",   256'(bus.win_data),   256'(0));
                    chk("rst_win_center", 256'(bus.win_center), 256'(0));
                    chk("rst_done",       256'(bus.done),       256'(0));
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    #1 chk("rst_no_done", 256'(bus.done), 256'(0));
                    aborted = 1;
                    fin = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        chk("run_finished", 256'(fin), 256'(1));
        if (!aborted) begin
            chk("samples_accepted", 256'(n_acc), 256'(DS));
            chk("windows_out",      256'(n_win), 256'(DS));
        end
    endtask

    initial begin
        logic [WS*DW-1:0] e;

        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.win_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_in_ready",   256'(bus.in_ready),   256'(0));
        chk("reset_win_valid",  256'(bus.win_valid),  256'(0));
        chk("reset_win_data",   256'(bus.win_data),   256'(0));
        chk("reset_win_center", 256'(bus.win_center), 256'(0));
        chk("reset_done",       256'(bus.done),       256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // in_valid while idle must not be taken
        @(negedge clk);
        bus.in_valid = 1'b1;
        #1 chk("idle_in_ready", 256'(bus.in_ready), 256'(0));
        bus.in_valid = 1'b0;

        // Expected windows worked out by hand from the padding rules.
        tbl[0].base = 10; tbl[0].center = 8;  tbl[0].exp = '{15, 16, 17, 18, 19, 20, 21};
        tbl[1].base = -5; tbl[1].center = 3;  tbl[1].exp = '{-5, -4, -3, -2, -1, 0, 1};
`ifdef SG_WIN_ZERO_PAD_EN
        tbl[2].base = 10; tbl[2].center = 0;  tbl[2].exp = '{0, 0, 0, 10, 11, 12, 13};
        tbl[3].base = 10; tbl[3].center = 15; tbl[3].exp = '{22, 23, 24, 25, 0, 0, 0};
        tbl[4].base = -5; tbl[4].center = 0;  tbl[4].exp = '{0, 0, 0, -5, -4, -3, -2};
        tbl[5].base = -5; tbl[5].center = 15; tbl[5].exp = '{7, 8, 9, 10, 0, 0, 0};
`else
        tbl[2].base = 10; tbl[2].center = 0;  tbl[2].exp = '{10, 10, 10, 10, 11, 12, 13};
        tbl[3].base = 10; tbl[3].center = 15; tbl[3].exp = '{22, 23, 24, 25, 25, 25, 25};
        tbl[4].base = -5; tbl[4].center = 0;  tbl[4].exp = '{-5, -5, -5, -5, -4, -3, -2};
        tbl[5].base = -5; tbl[5].center = 15; tbl[5].exp = '{7, 8, 9, 10, 10, 10, 10};
`endif

        for (int t = 0; t < 6; t++) begin
            fill_ramp(tbl[t].base);
            run(0, 0, -1, -1);
            e = '0;
            for (int k = 0; k < WS; k++) e[k*DW +: DW] = DW'(tbl[t].exp[k]);
            chk($sformatf("tbl%0d_c%0d", t, tbl[t].center), 256'(cap[tbl[t].center]), 256'(e));
        end

        // start pulsed mid-STREAM and in_valid held high past the last sample
        fill_ramp(10);
        run(0, 0, 8, -1);

        // backpressure with toggling win_ready and random in_valid
        fill_ramp(10);
        run(1, 1, -1, -1);
        fill_rand();
        run(1, 1, -1, -1);

        // reset after 9 windows, then a clean full run
        fill_ramp(10);
        run(0, 0, -1, 9);
        run(0, 0, -1, -1);
        fill_ramp(10);
        e = '0;
        for (int k = 0; k < WS; k++) e[k*DW +: DW] = DW'(22 + (k < 4 ? k : 3));
`ifdef SG_WIN_ZERO_PAD_EN
        for (int k = 4; k < WS; k++) e[k*DW +: DW] = '0;
`endif
        chk("after_reset_c15", 256'(cap[15]), 256'(e));

        // randomized data and handshakes
        for (int r = 0; r < 4; r++) begin
            fill_rand();
            run(1, 2, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
